ifetch_ctrl: RTL and testbench

Instruction-fetch sequencer that owns the I_memory address port. It holds the program counter and issues one read per instruction against the 1-cycle synchronous-read I_memory. It captures the returned word and hands it to decode over a valid/ready handshake. It also handles branch/jump redirects, HALT detection and fetch counting.

---
 rtl/ifetch_ctrl.sv | 130 +++++++++++++
 tb/tb_ifetch_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch sequencer: drives the I_memory address and captures each returned word.
// It hands the word to decode over valid/ready and handles redirects, HALT and fetch counting.
module ifetch_ctrl #(
   parameter int         MEM_SPACE = 8,
   parameter int         ISIZE     = 32,
   parameter logic [3:0] HALT_OP   = 4'hF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [MEM_SPACE-1:0] start_addr,
   output logic [MEM_SPACE-1:0] mem_addr,
   input  logic [ISIZE-1:0]     mem_data,
   output logic [ISIZE-1:0]     inst,
   output logic [MEM_SPACE-1:0] inst_pc,
   output logic                 inst_valid,
   input  logic                 inst_ready,
   input  logic                 redirect_valid,
   input  logic [MEM_SPACE-1:0] redirect_addr,
   output logic                 busy,
   output logic                 done,
   output logic [15:0]          fetch_cnt
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_FETCH   = 3'd1,
      S_CAPTURE = 3'd2,
      S_HOLD    = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   state_t               state_q;
   logic [MEM_SPACE-1:0] pc_q;
   logic [ISIZE-1:0]     inst_q;
   logic [MEM_SPACE-1:0] inst_pc_q;
   logic                 inst_valid_q;
   logic                 busy_q;
   logic                 done_q;
   logic [15:0]          fetch_cnt_q;

   logic                 handshake_d;
   logic                 is_halt_d;
   logic [15:0]          fetch_cnt_d;
   logic [MEM_SPACE-1:0] pc_inc_d;

   assign handshake_d = inst_valid_q && inst_ready;
   assign is_halt_d   = (inst_q[ISIZE-1 -: 4] == HALT_OP);
   assign fetch_cnt_d = (fetch_cnt_q == 16'hFFFF) ? fetch_cnt_q : fetch_cnt_q + 16'd1;
   assign pc_inc_d    = pc_q + MEM_SPACE'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         pc_q         <= '0;
         inst_q       <= '0;
         inst_pc_q    <= '0;
         inst_valid_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         fetch_cnt_q  <= '0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start) begin
                  pc_q        <= start_addr;
                  fetch_cnt_q <= '0;
                  busy_q      <= 1'b1;
                  done_q      <= 1'b0;
                  state_q     <= S_FETCH;
               end
            end
            S_FETCH: begin
               // A redirect here simply re-presents the new address for another cycle.
               if (redirect_valid) begin
                  pc_q    <= redirect_addr;
                  state_q <= S_FETCH;
               end else begin
                  state_q <= S_CAPTURE;
               end
            end
            S_CAPTURE: begin
               if (redirect_valid) begin
                  pc_q    <= redirect_addr;
                  state_q <= S_FETCH;
               end else begin
                  inst_q       <= mem_data;
                  inst_pc_q    <= pc_q;
                  inst_valid_q <= 1'b1;
                  pc_q         <= pc_inc_d;
                  state_q      <= S_HOLD;
               end
            end
            S_HOLD: begin
               if (handshake_d) begin
                  // An accepted HALT ends fetching even if a redirect arrives with it.
                  fetch_cnt_q  <= fetch_cnt_d;
                  inst_valid_q <= 1'b0;
                  if (is_halt_d) begin
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= S_DONE;
                  end else begin
                     if (redirect_valid) begin
                        pc_q <= redirect_addr;
                     end
                     state_q <= S_FETCH;
                  end
               end else if (redirect_valid) begin
                  pc_q         <= redirect_addr;
                  inst_valid_q <= 1'b0;
                  state_q      <= S_FETCH;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign mem_addr   = pc_q;
   assign inst       = inst_q;
   assign inst_pc    = inst_pc_q;
   assign inst_valid = inst_valid_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign fetch_cnt  = fetch_cnt_q;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Bench for ifetch_ctrl: a bench-owned synchronous memory and a transaction-level reference model.
// The model tracks the fetch address, elapsed cycles and accept count from the behavioural rules.
module tb_ifetch_ctrl;

   logic        clk = 1'b0;
   logic        rst, start, inst_ready, redirect_valid;
   logic [7:0]  start_addr, mem_addr, inst_pc, redirect_addr;
   logic [31:0] mem_data, inst;
   logic        inst_valid, busy, done;
   logic [15:0] fetch_cnt;

   logic [31:0] mem [256];

   always #5 clk = ~clk;

   always @(posedge clk) mem_data <= mem[mem_addr];

   ifetch_ctrl #(.MEM_SPACE(8), .ISIZE(32), .HALT_OP(4'hF)) dut (
      .clk(clk), .rst(rst), .start(start), .start_addr(start_addr),
      .mem_addr(mem_addr), .mem_data(mem_data), .inst(inst), .inst_pc(inst_pc),
      .inst_valid(inst_valid), .inst_ready(inst_ready),
      .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
      .busy(busy), .done(done), .fetch_cnt(fetch_cnt)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   bit         m_run  = 1'b0;
   bit         m_halt = 1'b0;
   bit         m_rstd = 1'b1;
   int         m_cnt  = 0;
   logic [7:0] m_addr = 8'h00;
   int         m_fcnt = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] plain_word();
      logic [31:0] w;
      w = $urandom;
      w[31:28] = 4'($urandom_range(0, 14));
      return w;
   endfunction

   // One clock cycle: check outputs, drive inputs, advance the model past the next edge.
   task automatic step(input bit r, input bit s, input logic [7:0] sa, input bit rdy,
                       input bit rv, input logic [7:0] ra);
      bit          exp_valid;
      logic [7:0]  exp_ma;
      logic [7:0]  nxt;
      logic [31:0] w;
      @(negedge clk);
      exp_valid = m_run && (m_cnt >= 2);
      nxt = 8'(m_addr + 8'd1);
      if (m_run)       exp_ma = (m_cnt >= 2) ? nxt : m_addr;
      else if (m_halt) exp_ma = nxt;
      else             exp_ma = 8'h00;
      check("inst_valid", {31'd0, inst_valid}, {31'd0, exp_valid});
      check("busy", {31'd0, busy}, {31'd0, m_run});
      check("done", {31'd0, done}, {31'd0, m_halt});
      check("fetch_cnt", {16'd0, fetch_cnt}, 32'(m_fcnt));
      check("mem_addr", {24'd0, mem_addr}, {24'd0, exp_ma});
      if (exp_valid) begin
         check("inst", inst, mem[m_addr]);
         check("inst_pc", {24'd0, inst_pc}, {24'd0, m_addr});
      end else if (m_rstd) begin
         check("inst_rst", inst, 32'd0);
         check("inst_pc_rst", {24'd0, inst_pc}, 32'd0);
      end

      rst = r; start = s; start_addr = sa; inst_ready = rdy;
      redirect_valid = rv; redirect_addr = ra;

      if (r) begin
         m_run = 1'b0; m_halt = 1'b0; m_rstd = 1'b1;
         m_cnt = 0; m_addr = 8'h00; m_fcnt = 0;
      end else if (!m_run) begin
         if (s) begin
            m_run = 1'b1; m_halt = 1'b0; m_rstd = 1'b0;
            m_cnt = 0; m_addr = sa; m_fcnt = 0;
         end
      end else if (exp_valid && rdy) begin
         w = mem[m_addr];
         m_fcnt = (m_fcnt == 65535) ? 65535 : m_fcnt + 1;
         $display("accept pc=%h inst=%h count=%0d redirect=%0b", m_addr, w, m_fcnt, rv);
         if (w[31:28] == 4'hF) begin
            m_run  = 1'b0;
            m_halt = 1'b1;
         end else begin
            m_addr = rv ? ra : nxt;
            m_cnt  = 0;
         end
      end else if (rv) begin
         m_addr = ra;
         m_cnt  = 0;
      end else if (m_cnt < 2) begin
         m_cnt++;
      end
   endtask

   task automatic idle_steps(input int n, input bit rdy);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, rdy, 1'b0, 8'h00);
   endtask

   task automatic fill_plain();
      for (int i = 0; i < 256; i++) mem[i] = plain_word();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      fill_plain();
      mem[0] = 32'h00000011;
      mem[1] = 32'h00000022;
      rst = 1'b1; start = 1'b0; start_addr = 8'h00; inst_ready = 1'b0;
      redirect_valid = 1'b0; redirect_addr = 8'h00;
      @(posedge clk);
      @(posedge clk);

      // Start and first fetches with decode always ready
      step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
      step(1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00);
      idle_steps(8, 1'b1);

      // Backpressure in HOLD, then release
      idle_steps(8, 1'b0);
      idle_steps(6, 1'b1);

      // Redirect during CAPTURE of address 5
      step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
      mem[5] = 32'h05050505;
      mem[8'h40] = 32'h40404040;
      step(1'b0, 1'b1, 8'h05, 1'b1, 1'b0, 8'h00);
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h40);
      idle_steps(6, 1'b1);

      // HALT at address 3, then stay done
      step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
      mem[3] = 32'hF0000000;
      step(1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00);
      idle_steps(24, 1'b1);
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h20);
      idle_steps(4, 1'b1);

      // Restart from DONE at 0xFF to wrap the PC
      step(1'b0, 1'b1, 8'hFF, 1'b1, 1'b0, 8'h00);
      idle_steps(20, 1'b1);

      // Reset while holding an instruction, then resume at 2
      step(1'b0, 1'b1, 8'h08, 1'b0, 1'b0, 8'h00);
      idle_steps(4, 1'b0);
      step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
      idle_steps(2, 1'b1);
      step(1'b0, 1'b1, 8'h02, 1'b1, 1'b0, 8'h00);
      idle_steps(10, 1'b1);

      // Randomized runs: random memory, backpressure, redirects, stray starts and resets
      for (int run = 0; run < 24; run++) begin
         step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
         fill_plain();
         for (int h = 0; h < 6; h++) mem[$urandom_range(0, 255)] = {4'hF, 28'($urandom)};
         step(1'b0, 1'b1, 8'($urandom), 1'b1, 1'b0, 8'h00);
         for (int c = 0; c < 220; c++) begin
            step(($urandom_range(0, 299) == 0),
                 ($urandom_range(0, 19) == 0),
                 8'($urandom),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 9) == 0),
                 8'($urandom));
         end
      end

      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
